// File: rtl/nic_dma_engine_if.sv
// Host and NIC-side signals of the DMA engine. Data buses are big-endian [0:DATA_WIDTH-1].
// Handshakes: tx and rx both transfer on a rising edge where valid & ready; valid never waits on ready.
interface nic_dma_engine_if #(
   parameter int DATA_WIDTH = 64
);
   logic [0:DATA_WIDTH-1] tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [0:DATA_WIDTH-1] rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [1:0]            nic_addr;
   logic [0:DATA_WIDTH-1] nic_d_in;
   logic [0:DATA_WIDTH-1] nic_d_out;
   logic                  nic_En;
   logic                  nic_WrEn;

   modport master (
      input  tx_data, tx_valid, rx_ready, nic_d_out,
      output tx_ready, rx_data, rx_valid, nic_addr, nic_d_in, nic_En, nic_WrEn
   );

   modport slave (
      output tx_data, tx_valid, rx_ready, nic_d_out,
      input  tx_ready, rx_data, rx_valid, nic_addr, nic_d_in, nic_En, nic_WrEn
   );
endinterface

// File: rtl/nic_dma_engine.sv
// Hardware initiator for the NIC register port: drains a host TX FIFO into the NIC output
// channel and the NIC input channel into an rx stream, polling status with round-robin arbitration.
module nic_dma_engine #(
   parameter int DATA_WIDTH = 64,
   parameter int TX_DEPTH   = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   nic_dma_engine_if.master     bus,
   output logic                 busy,
   output logic [CNT_WIDTH-1:0] tx_sent_cnt,
   output logic [CNT_WIDTH-1:0] rx_recv_cnt,
   output logic [2:0]           dbg_state
);
   localparam int AW = $clog2(TX_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(TX_DEPTH);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] OSTAT_RD  = 3'd1;
   localparam logic [2:0] OSTAT_CHK = 3'd2;
   localparam logic [2:0] OUT_WR    = 3'd3;
   localparam logic [2:0] ISTAT_RD  = 3'd4;
   localparam logic [2:0] ISTAT_CHK = 3'd5;
   localparam logic [2:0] IN_RD     = 3'd6;
   localparam logic [2:0] IN_CAP    = 3'd7;

   localparam logic GRANT_TX = 1'b0;
   localparam logic GRANT_RX = 1'b1;

   logic [2:0]            state, state_nxt;
   logic                  last_grant;
   logic [0:DATA_WIDTH-1] mem [TX_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           count;
   logic                  push, pop, tx_req, rx_req, status_bit;

   assign bus.tx_ready = (count < FULL_CNT);
   assign push         = bus.tx_valid & bus.tx_ready;
   assign pop          = (state == OUT_WR);
   assign tx_req       = (count != '0);
   assign rx_req       = ~bus.rx_valid;
   // NIC status flag sits in the last bit of the big-endian word
   assign status_bit   = bus.nic_d_out[DATA_WIDTH-1];
   assign busy         = (state != IDLE);
   assign dbg_state    = state;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (tx_req && (!rx_req || last_grant == GRANT_RX)) state_nxt = OSTAT_RD;
            else if (rx_req)                                  state_nxt = ISTAT_RD;
         end
         OSTAT_RD:  state_nxt = OSTAT_CHK;
         OSTAT_CHK: state_nxt = status_bit ? IDLE : OUT_WR;
         OUT_WR:    state_nxt = IDLE;
         ISTAT_RD:  state_nxt = ISTAT_CHK;
         ISTAT_CHK: state_nxt = status_bit ? IN_RD : IDLE;
         IN_RD:     state_nxt = IN_CAP;
         IN_CAP:    state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.nic_En   = 1'b0;
      bus.nic_WrEn = 1'b0;
      bus.nic_addr = 2'b00;
      bus.nic_d_in = '0;
      case (state)
         OSTAT_RD: begin bus.nic_En = 1'b1; bus.nic_addr = 2'b11; end
         ISTAT_RD: begin bus.nic_En = 1'b1; bus.nic_addr = 2'b01; end
         IN_RD:    begin bus.nic_En = 1'b1; bus.nic_addr = 2'b00; end
         OUT_WR: begin
            bus.nic_En   = 1'b1;
            bus.nic_WrEn = 1'b1;
            bus.nic_addr = 2'b10;
            bus.nic_d_in = mem[rd_ptr];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= GRANT_TX;
      end else begin
         state <= state_nxt;
         if ((state == OSTAT_CHK && status_bit) || state == OUT_WR)
            last_grant <= GRANT_TX;
         else if ((state == ISTAT_CHK && !status_bit) || state == IN_CAP)
            last_grant <= GRANT_RX;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.tx_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         tx_sent_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            tx_sent_cnt <= tx_sent_cnt + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Capture is only reachable with rx_valid low, so it never collides with the consume edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.rx_data  <= '0;
         bus.rx_valid <= 1'b0;
         rx_recv_cnt  <= '0;
      end else if (state == IN_CAP) begin
         bus.rx_data  <= bus.nic_d_out;
         bus.rx_valid <= 1'b1;
         rx_recv_cnt  <= rx_recv_cnt + 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
         bus.rx_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_nic_dma_engine.sv
// Bench for nic_dma_engine: NIC register model, host driver and scoreboards for the
// TX write path and RX capture path, plus arbitration and counter-wrap scenarios.
module tb_nic_dma_engine;
   localparam int DW = 64;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   nic_dma_engine_if #(.DATA_WIDTH(DW)) bus ();
   logic          busy;
   logic [CW-1:0] tx_sent_cnt, rx_recv_cnt;
   logic [2:0]    dbg_state;

   nic_dma_engine #(.DATA_WIDTH(DW), .TX_DEPTH(4), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .bus(bus), .busy(busy),
      .tx_sent_cnt(tx_sent_cnt), .rx_recv_cnt(rx_recv_cnt), .dbg_state(dbg_state)
   );

   int checks = 0;
   int errors = 0;
   int exp_tx_cnt = 0;
   int exp_rx_cnt = 0;
   logic [DW-1:0] exp_q[$], wr_obs_q[$], rx_exp_q[$], rx_obs_q[$];
   logic [2:0]    acc_q[$];

   // NIC model knobs and observation counters
   logic          out_stuck = 1'b0;
   int            out_full_limit = 0;
   int            in_avail = 0;
   logic [DW-1:0] in_buf = '0;
   int            ostat_polls = 0;
   int            inbuf_reads = 0;
   int            wr_total = 0;
   logic          en_prev = 1'b0;
   logic          en_double = 1'b0;

   always @(posedge clk) begin
      en_prev <= bus.nic_En;
      if (en_prev && bus.nic_En) en_double <= 1'b1;
      if (bus.rx_valid && bus.rx_ready) rx_obs_q.push_back(bus.rx_data);
      bus.nic_d_out <= {$urandom, $urandom};
      if (bus.nic_En) begin
         acc_q.push_back({bus.nic_WrEn, bus.nic_addr});
         if (bus.nic_WrEn) begin
            if (bus.nic_addr == 2'b10) begin
               wr_obs_q.push_back(bus.nic_d_in);
               wr_total <= wr_total + 1;
            end
         end else begin
            case (bus.nic_addr)
               2'b11: begin
                  bus.nic_d_out <= (out_stuck || ostat_polls < out_full_limit) ? DW'(1) : DW'(0);
                  ostat_polls   <= ostat_polls + 1;
               end
               2'b01: bus.nic_d_out <= (inbuf_reads < in_avail) ? DW'(1) : DW'(0);
               2'b00: begin
                  bus.nic_d_out <= in_buf;
                  inbuf_reads   <= inbuf_reads + 1;
               end
               default: ;
            endcase
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic push_pkt(input logic [DW-1:0] d, input int bound, output bit ok);
      int n = 0;
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      while (!bus.tx_ready && n < bound) begin
         @(negedge clk);
         n++;
      end
      ok = bus.tx_ready;
      if (ok) exp_q.push_back(d);
      @(negedge clk);
      bus.tx_valid = 1'b0;
   endtask

   task automatic wait_drain(input int bound, output bit ok);
      int n = 0;
      while ((wr_obs_q.size() < exp_q.size() || rx_obs_q.size() < rx_exp_q.size()) && n < bound) begin
         @(negedge clk);
         n++;
      end
      ok = (wr_obs_q.size() >= exp_q.size()) && (rx_obs_q.size() >= rx_exp_q.size());
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset();
      logic [DW-1:0] e, o;
      bit ok;
      reset = 1'b0;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 64'h0000_0000_0000_1111;
      bus.rx_ready = 1'b0;
      in_buf   = 64'hDEAD_BEEF_0000_0042;
      in_avail = inbuf_reads + 1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.nic_En, bus.nic_WrEn, bus.nic_addr} !== 4'b0000 || bus.nic_d_in !== '0) begin
         errors++;
         $display("FAIL reset_bus: got en=%b wr=%b addr=%b d_in=%h required all 0",
                  bus.nic_En, bus.nic_WrEn, bus.nic_addr, bus.nic_d_in);
      end
      checks++;
      if (bus.rx_valid !== 1'b0 || bus.rx_data !== '0) begin
         errors++;
         $display("FAIL reset_rx: got valid=%b data=%h required 0", bus.rx_valid, bus.rx_data);
      end
      checks++;
      if (tx_sent_cnt !== '0 || rx_recv_cnt !== '0) begin
         errors++;
         $display("FAIL reset_cnt: got tx=%0d rx=%0d required 0", tx_sent_cnt, rx_recv_cnt);
      end
      checks++;
      if (busy !== 1'b0 || bus.tx_ready !== 1'b1 || dbg_state !== 3'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b tx_ready=%b state=%0d required 0/1/0",
                  busy, bus.tx_ready, dbg_state);
      end
      reset = 1'b1;
      exp_q.push_back(64'h0000_0000_0000_1111);
      exp_tx_cnt++;
      rx_exp_q.push_back(in_buf);
      exp_rx_cnt++;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_busy: got %b required 1", busy);
      end
      bus.rx_ready = 1'b1;
      wait_drain(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_drain: got timeout required traffic done");
      end
      while (exp_q.size() > 0 && wr_obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = wr_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_tx_data: got %h required %h", o, e);
         end
      end
      while (rx_exp_q.size() > 0 && rx_obs_q.size() > 0) begin
         e = rx_exp_q.pop_front();
         o = rx_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_rx_data: got %h required %h", o, e);
         end
      end
   endtask

   task automatic test_tx_basic();
      logic [DW-1:0] e, o;
      logic [2:0] tx_acc[$];
      bit ok;
      acc_q.delete();
      push_pkt(64'hA5A5_0000_0000_0001, 20, ok);
      exp_tx_cnt++;
      wait_drain(200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL tx_basic_drain: got timeout required one write");
      end
      while (exp_q.size() > 0 && wr_obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = wr_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL tx_basic_data: got %h required %h", o, e);
         end
      end
      foreach (acc_q[i]) if (acc_q[i][1]) tx_acc.push_back(acc_q[i]);
      checks++;
      if (tx_acc.size() != 2 || tx_acc[0] !== 3'b011 || tx_acc[1] !== 3'b110) begin
         errors++;
         $display("FAIL tx_basic_seq: got %0d tx accesses (first %b) required read 11 then write 10",
                  tx_acc.size(), (tx_acc.size() > 0) ? tx_acc[0] : 3'bxxx);
      end
      checks++;
      if (tx_sent_cnt !== CW'(exp_tx_cnt)) begin
         errors++;
         $display("FAIL tx_basic_cnt: got %0d required %0d", tx_sent_cnt, exp_tx_cnt);
      end
   endtask

   task automatic test_ostat_full();
      logic [DW-1:0] e, o;
      logic [2:0] tx_acc[$];
      int viol = 0;
      int n_ostat = 0;
      bit seen_rx = 1'b0;
      bit ok;
      out_full_limit = ostat_polls + 3;
      acc_q.delete();
      push_pkt(64'h5A5A_1234_0000_0002, 20, ok);
      exp_tx_cnt++;
      wait_drain(300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ostat_drain: got timeout required one write");
      end
      while (exp_q.size() > 0 && wr_obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = wr_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL ostat_data: got %h required %h", o, e);
         end
      end
      foreach (acc_q[i]) begin
         if (acc_q[i][1]) tx_acc.push_back(acc_q[i]);
         if (acc_q[i] == 3'b001) seen_rx = 1'b1;
         if (acc_q[i] == 3'b011) begin
            if (n_ostat > 0 && !seen_rx) viol++;
            n_ostat++;
            seen_rx = 1'b0;
         end
      end
      checks++;
      if (tx_acc.size() != 5 || tx_acc[3] !== 3'b011 || tx_acc[4] !== 3'b110) begin
         errors++;
         $display("FAIL ostat_seq: got %0d tx accesses required 4 status reads then 1 write", tx_acc.size());
      end
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL ostat_interleave: got %0d polls without rx poll between required 0", viol);
      end
      checks++;
      if (bus.tx_ready !== 1'b1 || wr_obs_q.size() != 0) begin
         errors++;
         $display("FAIL ostat_empty: got tx_ready=%b extra_writes=%0d required 1/0",
                  bus.tx_ready, wr_obs_q.size());
      end
   endtask

   task automatic test_rx();
      logic [DW-1:0] e, o;
      logic [DW-1:0] pkt = 64'h0123_4567_89AB_CDEF;
      logic [DW-1:0] tpk = 64'h7777_0000_0000_0003;
      int n = 0;
      int n_inrd = 0;
      bit ok;
      bus.rx_ready = 1'b0;
      in_buf   = pkt;
      in_avail = inbuf_reads + 1000;
      rx_exp_q.push_back(pkt);
      exp_rx_cnt++;
      while (!bus.rx_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.rx_valid !== 1'b1 || bus.rx_data !== pkt) begin
         errors++;
         $display("FAIL rx_capture: got valid=%b data=%h required 1/%h", bus.rx_valid, bus.rx_data, pkt);
      end
      acc_q.delete();
      repeat (10) @(negedge clk);
      foreach (acc_q[i]) if (acc_q[i] == 3'b000) n_inrd++;
      checks++;
      if (n_inrd != 0 || bus.rx_valid !== 1'b1 || bus.rx_data !== pkt) begin
         errors++;
         $display("FAIL rx_hold: got inbuf_reads=%0d valid=%b data=%h required 0/1/%h",
                  n_inrd, bus.rx_valid, bus.rx_data, pkt);
      end
      // Uncontended TX latency while rx is held: write at the third cycle after the push edge
      bus.tx_valid = 1'b1;
      bus.tx_data  = tpk;
      exp_q.push_back(tpk);
      exp_tx_cnt++;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.nic_WrEn !== 1'b0) begin
         errors++;
         $display("FAIL tx_latency_early: got wr=%b at E+2 required 0", bus.nic_WrEn);
      end
      @(negedge clk);
      checks++;
      if (bus.nic_En !== 1'b1 || bus.nic_WrEn !== 1'b1 || bus.nic_addr !== 2'b10 || bus.nic_d_in !== tpk) begin
         errors++;
         $display("FAIL tx_latency: got en=%b wr=%b addr=%b d_in=%h required 1/1/10/%h",
                  bus.nic_En, bus.nic_WrEn, bus.nic_addr, bus.nic_d_in, tpk);
      end
      in_avail = inbuf_reads;
      bus.rx_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.rx_valid !== 1'b0) begin
         errors++;
         $display("FAIL rx_consume: got valid=%b required 0", bus.rx_valid);
      end
      wait_drain(200, ok);
      while (rx_exp_q.size() > 0 && rx_obs_q.size() > 0) begin
         e = rx_exp_q.pop_front();
         o = rx_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rx_data: got %h required %h", o, e);
         end
      end
      while (exp_q.size() > 0 && wr_obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = wr_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rx_tx_data: got %h required %h", o, e);
         end
      end
      checks++;
      if (rx_recv_cnt !== CW'(exp_rx_cnt)) begin
         errors++;
         $display("FAIL rx_cnt: got %0d required %0d", rx_recv_cnt, exp_rx_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e, o;
      int n = 0;
      bit ok;
      out_stuck = 1'b1;
      for (int i = 0; i < 4; i++) begin
         push_pkt(64'hB000_0000_0000_0000 | 64'(i), 1, ok);
         exp_tx_cnt++;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL b2b_accept%0d: got tx_ready=0 required 1", i);
         end
      end
      checks++;
      if (bus.tx_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_full: got tx_ready=%b required 0", bus.tx_ready);
      end
      bus.tx_valid = 1'b1;
      bus.tx_data  = 64'hB000_0000_0000_0004;
      repeat (8) @(negedge clk);
      checks++;
      if (bus.tx_ready !== 1'b0 || wr_obs_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_stall: got tx_ready=%b writes=%0d required 0/0", bus.tx_ready, wr_obs_q.size());
      end
      out_stuck = 1'b0;
      while (!bus.tx_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.tx_ready !== 1'b1 || wr_obs_q.size() != 1) begin
         errors++;
         $display("FAIL b2b_release: got tx_ready=%b writes=%0d required 1/1", bus.tx_ready, wr_obs_q.size());
      end
      exp_q.push_back(64'hB000_0000_0000_0004);
      exp_tx_cnt++;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      wait_drain(300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_drain: got timeout required 5 writes");
      end
      while (exp_q.size() > 0 && wr_obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = wr_obs_q.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_data: got %h required %h", o, e);
         end
      end
      checks++;
      if (tx_sent_cnt !== CW'(exp_tx_cnt)) begin
         errors++;
         $display("FAIL b2b_cnt: got %0d required %0d", tx_sent_cnt, exp_tx_cnt);
      end
   endtask

   task automatic test_alternate_wrap();
      int n = 0;
      int viol = 0;
      int grants = 0;
      logic [2:0] prev = 3'b111;
      out_stuck = 1'b0;
      bus.rx_ready = 1'b1;
      in_buf   = 64'h0F0F_0F0F_0000_0005;
      in_avail = inbuf_reads + 100000;
      bus.tx_valid = 1'b1;
      bus.tx_data  = 64'hC0DE_0000_0000_0006;
      repeat (20) @(negedge clk);
      acc_q.delete();
      while (wr_total != 255 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_sent_cnt !== CW'(255)) begin
         errors++;
         $display("FAIL wrap_preload: got %0d required 255 (writes=%0d)", tx_sent_cnt, wr_total);
      end
      n = 0;
      while (wr_total != 256 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tx_sent_cnt !== CW'(0)) begin
         errors++;
         $display("FAIL wrap_zero: got %0d required 0 (writes=%0d)", tx_sent_cnt, wr_total);
      end
      foreach (acc_q[i]) begin
         if (acc_q[i] == 3'b011 || acc_q[i] == 3'b001) begin
            if (acc_q[i] == prev) viol++;
            prev = acc_q[i];
            grants++;
         end
      end
      checks++;
      if (viol != 0 || grants < 100) begin
         errors++;
         $display("FAIL alternate: got %0d repeated grants of %0d required 0 of >=100", viol, grants);
      end
      bus.tx_valid = 1'b0;
      in_avail = inbuf_reads;
      repeat (60) @(negedge clk);
      checks++;
      if (tx_sent_cnt !== CW'(wr_total) || rx_recv_cnt !== CW'(inbuf_reads)) begin
         errors++;
         $display("FAIL wrap_final_cnt: got tx=%0d rx=%0d required %0d/%0d",
                  tx_sent_cnt, rx_recv_cnt, CW'(wr_total), CW'(inbuf_reads));
      end
      checks++;
      if (en_double !== 1'b0) begin
         errors++;
         $display("FAIL en_pulse: got back-to-back nic_En required single-cycle strobes");
      end
      exp_q.delete();
      wr_obs_q.delete();
      rx_exp_q.delete();
      rx_obs_q.delete();
   endtask

   initial begin
      reset        = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.rx_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_tx_basic();
      test_ostat_full();
      test_rx();
      test_back_to_back();
      test_alternate_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nic_dma_engine.md
Name: nic_dma_engine

Overview:
- Hardware initiator for the NIC's processor-side register interface (addr/d_in/d_out/nicEn/nicEnWr). It replaces a CPU at nodes that only move packets.
- Pushes host packets into the NIC output channel and drains the NIC input channel to a valid/ready stream.
- Polls NIC status registers and arbitrates TX/RX round-robin.
- Used for traffic-generator and I/O-bridge nodes on the mesh.

Parameters:
DATA_WIDTH, 64, packet/bus width (big-endian [0:DATA_WIDTH-1])
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
CNT_WIDTH, 16, width of packet counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
tx_data  in  DATA_WIDTH  host packet to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO can accept (count < TX_DEPTH)
rx_data  out  DATA_WIDTH  packet received from NIC
rx_valid  out  1  rx_data holds a packet
rx_ready  in  1  host consumes rx_data
nic_addr  out  2  NIC register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
nic_d_in  out  DATA_WIDTH  write data to NIC
nic_d_out  in  DATA_WIDTH  NIC read data, valid the cycle after a read access
nic_En  out  1  NIC access strobe
nic_WrEn  out  1  1 = write, 0 = read
busy  out  1  FSM not in IDLE
tx_sent_cnt  out  CNT_WIDTH  packets written to NIC
rx_recv_cnt  out  CNT_WIDTH  packets read from NIC

Behaviour:
- Reset (reset=0, async) forces state to IDLE, empties the FIFO, and clears last_grant, rx_data, rx_valid and both counters.
  - During reset: nic_En=0, nic_WrEn=0, nic_addr=00, nic_d_in=0, busy=0, tx_ready=1.
  - A packet in flight when reset asserts is lost. No partial NIC write is issued.
- TX FIFO: push when tx_valid&tx_ready. tx_ready is combinational from the registered count.
  - When the FIFO is full, tx_ready=0 even if a pop occurs in the same cycle.
  - Pop occurs on the OUT_WR edge. Pointers wrap modulo TX_DEPTH.
- NIC bus outputs are Moore outputs decoded from state. There is at most one access per cycle, and nic_En is high for exactly one cycle per access.
  - Outside access states: nic_En=0, nic_WrEn=0, nic_addr=00, nic_d_in=0.
- States:
  - IDLE: tx_req = FIFO non-empty; rx_req = !rx_valid.
    - Both requesting: grant the side not in last_grant.
    - Grant TX -> OSTAT_RD; grant RX -> ISTAT_RD; neither -> stay.
  - OSTAT_RD: nic_En=1, nic_WrEn=0, addr=11 -> OSTAT_CHK.
  - OSTAT_CHK: sample nic_d_out[DATA_WIDTH-1].
    - 0 (not full) -> OUT_WR.
    - 1 -> IDLE, last_grant=TX.
  - OUT_WR: nic_En=1, nic_WrEn=1, addr=10, nic_d_in=FIFO head. Pop, tx_sent_cnt+1, last_grant=TX -> IDLE.
  - ISTAT_RD: nic_En=1, nic_WrEn=0, addr=01 -> ISTAT_CHK.
  - ISTAT_CHK: sample nic_d_out[DATA_WIDTH-1].
    - 1 (packet present) -> IN_RD.
    - 0 -> IDLE, last_grant=RX.
  - IN_RD: nic_En=1, nic_WrEn=0, addr=00 -> IN_CAP.
  - IN_CAP: rx_data<=nic_d_out, rx_valid<=1, rx_recv_cnt+1, last_grant=RX -> IDLE.
- RX output: rx_valid clears on the edge where rx_valid&rx_ready. rx_data holds its value until the next capture.
  - Capture occurs only when rx_valid=0, so no overwrite is possible.
  - rx_data and rx_valid do not change while rx_valid=1 and rx_ready=0.
- Latency:
  - TX: push accepted at edge E -> OUT_WR asserted at cycle E+3, uncontended with NIC not full.
  - RX: ISTAT_RD -> rx_valid high 4 cycles later.
- Counters wrap from all-ones to 0.
- busy = (state != IDLE).

Test Plan:
- Reset with tx_valid=1 and a NIC model holding a packet -> all bus outputs 0, rx_valid=0, counters 0, busy=0; release -> normal operation starts next cycle.
- Push 0xA5A5_0000_0000_0001; out-status=0; in-status=0 -> 4-cycle TX sequence completes.
  - Required: read 11, then write 10 with d_in=0xA5A5_0000_0000_0001; tx_sent_cnt=1.
- out-status=1 for 3 polls, then 0, with 1 packet queued -> 3 OSTAT_RD/OSTAT_CHK rounds interleaved with RX polls, then exactly one write; FIFO empties.
- NIC in-status=1 with in-buf=0x0123_4567_89AB_CDEF; rx_ready=0 -> rx_data=0x0123_4567_89AB_CDEF, rx_valid=1.
  - No further addr=00 reads while rx_valid=1.
  - Assert rx_ready -> rx_valid=0; rx_recv_cnt=1.
- Push 5 packets back-to-back with out-status stuck at 1 -> tx_ready=0 after 4 pushes; 5th push stalls until the first OUT_WR completes.
- TX and RX both pending continuously -> grants alternate TX, RX, TX, RX, ...; with 0xFFFF preloaded via 65535 transfers, the next transfer wraps the counter to 0.
